// File: rtl/dc_bus_volt_monitor.sv
// DC-bus voltage monitor: block averaging, hysteretic zone classification with persistence,
// over-voltage fault latch and LED drive. Define VOLT_MON_STUCK_EN to add stuck-ADC detection.
module dc_bus_volt_monitor #(
  parameter int          AVG_LOG2 = 3,
  parameter int          PERSIST  = 16,
  parameter int          SETTLE   = 4,
  parameter logic [15:0] TH_LOW   = 16'h0860,
  parameter logic [15:0] TH_OK_LO = 16'h08B0,
  parameter logic [15:0] TH_OK_HI = 16'h0C0C,
  parameter logic [15:0] HYST     = 16'h0010,
  parameter int          STUCK_N  = 64
) (
  input  logic        clk,
  input  logic        sys_rst_n,
  input  logic [15:0] volt_in,
  input  logic        volt_vld,
  input  logic        clr_fault,
  output logic [15:0] avg_volt,
  output logic        avg_vld,
  output logic [2:0]  zone,
  output logic        zone_vld,
  output logic        enable_out,
  output logic        fault_latched,
  output logic        adc_stuck,
  output logic [4:0]  led_n
);

  localparam int ACC_W = 16 + AVG_LOG2;
  localparam int BLK   = 1 << AVG_LOG2;

  typedef enum logic [2:0] {
    ZONE_UNKNOWN = 3'd0,
    ZONE_LOW     = 3'd1,
    ZONE_UNDER   = 3'd2,
    ZONE_OK      = 3'd3,
    ZONE_OVER    = 3'd4
  } zone_t;

  if (AVG_LOG2 < 0 || AVG_LOG2 > 6) begin : g_bad_avg_log2
    $error("AVG_LOG2 out of range 0..6");
  end
  if (PERSIST < 1 || PERSIST > 255) begin : g_bad_persist
    $error("PERSIST out of range 1..255");
  end
  if (SETTLE < 0 || SETTLE > 255) begin : g_bad_settle
    $error("SETTLE out of range 0..255");
  end
  if (STUCK_N < 1 || STUCK_N > 65535) begin : g_bad_stuck_n
    $error("STUCK_N out of range 1..65535");
  end

  logic [7:0]       settle_cnt_reg;
  logic [6:0]       smp_cnt_reg;
  logic [ACC_W-1:0] acc_reg;
  logic [ACC_W-1:0] sum_reg;
  logic [ACC_W-1:0] acc_sum;
  logic             sum_vld_reg;
  logic [15:0]      avg_reg;
  logic             avg_vld_reg;
  logic             settled;
  logic             accept;
  logic             block_end;

  zone_t       zone_reg, zone_next;
  zone_t       prev_cand_reg, prev_cand_next;
  zone_t       raw_zone, cand_zone;
  logic [7:0]  pcnt_reg, pcnt_next, pcnt_inc;
  logic        zone_vld_reg, zone_vld_next;
  logic        fault_reg, fault_next;
  logic        enable_reg, enable_next;
  logic [4:0]  led_reg, led_next;
  logic        stuck_reg;
  logic        stuck_set_reg;

  logic        has_up, has_lo, outside;
  logic [15:0] up_b, lo_b, up_h, lo_h;
  logic [16:0] up_sum, lo_dif;

  assign settled   = (settle_cnt_reg == 8'(SETTLE));
  assign accept    = volt_vld && settled;
  assign block_end = (smp_cnt_reg == 7'(BLK - 1));
  assign acc_sum   = acc_reg + ACC_W'(volt_in);

  // Sum is registered at the block-end edge, then scaled one edge later, so a strobe
  // arriving right after a block end starts the next block without stalling.
  always_ff @(posedge clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      settle_cnt_reg <= '0;
      smp_cnt_reg    <= '0;
      acc_reg        <= '0;
      sum_reg        <= '0;
      sum_vld_reg    <= 1'b0;
      avg_reg        <= '0;
      avg_vld_reg    <= 1'b0;
    end else begin
      sum_vld_reg <= 1'b0;
      avg_vld_reg <= sum_vld_reg;
      if (volt_vld && !settled) begin
        settle_cnt_reg <= settle_cnt_reg + 8'd1;
      end
      if (accept) begin
        if (block_end) begin
          acc_reg     <= '0;
          smp_cnt_reg <= '0;
          sum_reg     <= acc_sum;
          sum_vld_reg <= 1'b1;
        end else begin
          acc_reg     <= acc_sum;
          smp_cnt_reg <= smp_cnt_reg + 7'd1;
        end
      end
      if (sum_vld_reg) begin
        avg_reg <= 16'(sum_reg >> AVG_LOG2);
      end
    end
  end

  // Raw class plus the widened (saturating) bounds of the zone currently held.
  always_comb begin
    if (avg_reg <= TH_LOW)        raw_zone = ZONE_LOW;
    else if (avg_reg <= TH_OK_LO) raw_zone = ZONE_UNDER;
    else if (avg_reg <= TH_OK_HI) raw_zone = ZONE_OK;
    else                          raw_zone = ZONE_OVER;

    has_up = 1'b0;
    has_lo = 1'b0;
    up_b   = 16'h0000;
    lo_b   = 16'h0000;
    case (zone_reg)
      ZONE_LOW:   begin has_up = 1'b1; up_b = TH_LOW; end
      ZONE_UNDER: begin has_up = 1'b1; up_b = TH_OK_LO; has_lo = 1'b1; lo_b = TH_LOW; end
      ZONE_OK:    begin has_up = 1'b1; up_b = TH_OK_HI; has_lo = 1'b1; lo_b = TH_OK_LO; end
      ZONE_OVER:  begin has_lo = 1'b1; lo_b = TH_OK_HI; end
      default:    ;
    endcase

    up_sum  = {1'b0, up_b} + {1'b0, HYST};
    lo_dif  = {1'b0, lo_b} - {1'b0, HYST};
    up_h    = up_sum[16] ? 16'hFFFF : up_sum[15:0];
    lo_h    = lo_dif[16] ? 16'h0000 : lo_dif[15:0];
    outside = (has_up && (avg_reg > up_h)) || (has_lo && (avg_reg <= lo_h));

    if (zone_reg == ZONE_UNKNOWN || outside) cand_zone = raw_zone;
    else                                     cand_zone = zone_reg;
  end

  always_comb begin
    zone_next      = zone_reg;
    prev_cand_next = prev_cand_reg;
    pcnt_next      = pcnt_reg;
    zone_vld_next  = 1'b0;
    pcnt_inc       = (cand_zone != prev_cand_reg) ? 8'd1 : pcnt_reg + 8'd1;

    if (avg_vld_reg) begin
      prev_cand_next = cand_zone;
      if (zone_reg == ZONE_UNKNOWN) begin
        zone_next     = cand_zone;
        zone_vld_next = 1'b1;
        pcnt_next     = 8'd0;
      end else if (cand_zone == zone_reg) begin
        pcnt_next = 8'd0;
      end else if (pcnt_inc >= 8'(PERSIST)) begin
        zone_next     = cand_zone;
        zone_vld_next = 1'b1;
        pcnt_next     = 8'd0;
      end else begin
        pcnt_next = pcnt_inc;
      end
    end

    // Setting dominates clearing; clearing is refused while still in OVER.
    if ((zone_vld_next && zone_next == ZONE_OVER) || stuck_set_reg) fault_next = 1'b1;
    else if (clr_fault && zone_reg != ZONE_OVER)                    fault_next = 1'b0;
    else                                                            fault_next = fault_reg;

    enable_next = (zone_next == ZONE_OK) && !fault_next;
    led_next    = {~fault_next,
                   ~(zone_next == ZONE_LOW),
                   ~(zone_next == ZONE_UNDER),
                   ~(zone_next == ZONE_OK),
                   ~(zone_next == ZONE_OVER)};
  end

  always_ff @(posedge clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      zone_reg      <= ZONE_UNKNOWN;
      prev_cand_reg <= ZONE_UNKNOWN;
      pcnt_reg      <= '0;
      zone_vld_reg  <= 1'b0;
      fault_reg     <= 1'b0;
      enable_reg    <= 1'b0;
      led_reg       <= 5'b11111;
    end else begin
      zone_reg      <= zone_next;
      prev_cand_reg <= prev_cand_next;
      pcnt_reg      <= pcnt_next;
      zone_vld_reg  <= zone_vld_next;
      fault_reg     <= fault_next;
      enable_reg    <= enable_next;
      led_reg       <= led_next;
    end
  end

`ifdef VOLT_MON_STUCK_EN
  logic [15:0] stuck_cmp_reg;
  logic [15:0] stuck_cnt_reg;
  logic [16:0] run_next;

  // Run length of identical raw codes, counting settle strobes too; saturates at STUCK_N.
  assign run_next = (stuck_cnt_reg != 16'd0 && volt_in == stuck_cmp_reg)
                    ? {1'b0, stuck_cnt_reg} + 17'd1 : 17'd1;

  always_ff @(posedge clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      stuck_cmp_reg <= '0;
      stuck_cnt_reg <= '0;
      stuck_reg     <= 1'b0;
      stuck_set_reg <= 1'b0;
    end else begin
      stuck_set_reg <= 1'b0;
      if (volt_vld) begin
        stuck_cmp_reg <= volt_in;
        if (run_next <= 17'(STUCK_N)) begin
          stuck_cnt_reg <= run_next[15:0];
        end
        if (run_next == 17'(STUCK_N)) begin
          stuck_reg     <= 1'b1;
          stuck_set_reg <= 1'b1;
        end else if (run_next == 17'd1) begin
          stuck_reg <= 1'b0;
        end
      end
    end
  end
`else
  assign stuck_reg     = 1'b0;
  assign stuck_set_reg = 1'b0;
`endif

  assign avg_volt      = avg_reg;
  assign avg_vld       = avg_vld_reg;
  assign zone          = zone_reg;
  assign zone_vld      = zone_vld_reg;
  assign enable_out    = enable_reg;
  assign fault_latched = fault_reg;
  assign adc_stuck     = stuck_reg;
  assign led_n         = led_reg;

endmodule

// File: tb/tb_dc_bus_volt_monitor.sv
// Scoreboard bench for dc_bus_volt_monitor: stimulus queues expected averages and zone
// commits; a negedge monitor pops and compares them whenever avg_vld / zone_vld pulse.
module tb_dc_bus_volt_monitor;

  logic        clk = 1'b0;
  logic        sys_rst_n;
  logic [15:0] volt_in;
  logic        volt_vld;
  logic        clr_fault;
  logic [15:0] avg_volt;
  logic        avg_vld;
  logic [2:0]  zone;
  logic        zone_vld;
  logic        enable_out;
  logic        fault_latched;
  logic        adc_stuck;
  logic [4:0]  led_n;

`ifdef VOLT_MON_STUCK_EN
  localparam logic [15:0] EXP_STUCK = 16'd1;
`else
  localparam logic [15:0] EXP_STUCK = 16'd0;
`endif

  typedef struct packed {
    logic [2:0] z;
    logic [4:0] led;
    logic       en;
  } zexp_t;

  zexp_t       zq[$];
  logic [15:0] aq[$];
  zexp_t       mon_ze;
  int          n_vec = 0;
  int          n_err = 0;

  dc_bus_volt_monitor dut (
    .clk(clk), .sys_rst_n(sys_rst_n), .volt_in(volt_in), .volt_vld(volt_vld),
    .clr_fault(clr_fault), .avg_volt(avg_volt), .avg_vld(avg_vld), .zone(zone),
    .zone_vld(zone_vld), .enable_out(enable_out), .fault_latched(fault_latched),
    .adc_stuck(adc_stuck), .led_n(led_n)
  );

  always #12 clk = ~clk;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end else begin
      $display("ok   %s: %h", name, act);
    end
  endtask

  always @(negedge clk) begin
    if (sys_rst_n === 1'b1) begin
      if (avg_vld) begin
        if (aq.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL avg_unexpected: got %h expected no average", avg_volt);
        end else begin
          chk("sb_avg_volt", avg_volt, aq.pop_front());
        end
      end
      if (zone_vld) begin
        if (zq.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL zone_unexpected: got zone %0d expected no commit", zone);
        end else begin
          mon_ze = zq.pop_front();
          chk("sb_zone", 16'(zone), 16'(mon_ze.z));
          chk("sb_led_n", 16'(led_n), 16'(mon_ze.led));
          chk("sb_enable", 16'(enable_out), 16'(mon_ze.en));
        end
      end
    end
  end

  task automatic send(input logic [15:0] v);
    @(negedge clk);
    volt_in  = v;
    volt_vld = 1'b1;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      volt_vld = 1'b0;
    end
  endtask

  // Codes v+1 / v-1 alternate so the block average is exactly v without a constant run.
  task automatic block(input logic [15:0] v);
    for (int i = 0; i < 4; i++) begin
      send(v + 16'd1);
      send(v - 16'd1);
    end
    aq.push_back(v);
  endtask

  task automatic settle4();
    repeat (4) send(16'hFFFF);
  endtask

  task automatic push_zone(input logic [2:0] z, input logic [4:0] led, input logic en);
    zq.push_back(zexp_t'{z: z, led: led, en: en});
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_avg_volt"}, avg_volt, 16'h0000);
    chk({tag, "_avg_vld"}, 16'(avg_vld), 16'd0);
    chk({tag, "_zone"}, 16'(zone), 16'd0);
    chk({tag, "_zone_vld"}, 16'(zone_vld), 16'd0);
    chk({tag, "_enable"}, 16'(enable_out), 16'd0);
    chk({tag, "_fault"}, 16'(fault_latched), 16'd0);
    chk({tag, "_stuck"}, 16'(adc_stuck), 16'd0);
    chk({tag, "_led_n"}, 16'(led_n), 16'h001F);
  endtask

  task automatic do_reset(input string tag);
    @(negedge clk);
    volt_vld  = 1'b0;
    sys_rst_n = 1'b0;
    #1;
    check_reset(tag);
    @(negedge clk);
    sys_rst_n = 1'b1;
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    sys_rst_n = 1'b0;
    volt_in   = 16'h0000;
    volt_vld  = 1'b0;
    clr_fault = 1'b0;
    repeat (3) @(negedge clk);
    check_reset("por");
    @(negedge clk);
    sys_rst_n = 1'b1;

    // Bring-up: settle strobes ignored, first average commits OK directly from UNKNOWN.
    settle4();
    push_zone(3'd3, 5'b11101, 1'b1);
    block(16'h0A00);
    @(negedge clk);
    volt_vld = 1'b0;
    chk("avg_vld_at_E", 16'(avg_vld), 16'd0);
    @(negedge clk);
    chk("avg_vld_at_E1", 16'(avg_vld), 16'd1);
    chk("zone_at_E1", 16'(zone), 16'd0);
    @(negedge clk);
    chk("zone_vld_at_E2", 16'(zone_vld), 16'd1);
    chk("enable_at_E2", 16'(enable_out), 16'd1);
    idle(4);

    repeat (20) block(16'h0C10);
    idle(6);
    chk("hyst_hold_zone", 16'(zone), 16'd3);

    repeat (15) block(16'h0C20);
    push_zone(3'd4, 5'b01110, 1'b0);
    block(16'h0C20);
    idle(6);
    chk("over_fault", 16'(fault_latched), 16'd1);
    chk("over_enable", 16'(enable_out), 16'd0);
    chk("over_led_n", 16'(led_n), 16'h000E);

    @(negedge clk);
    clr_fault = 1'b1;
    repeat (3) @(negedge clk);
    clr_fault = 1'b0;
    chk("clr_in_over_fault", 16'(fault_latched), 16'd1);

    repeat (15) block(16'h0A00);
    push_zone(3'd3, 5'b01101, 1'b0);
    block(16'h0A00);
    idle(6);
    chk("ok_fault_still", 16'(fault_latched), 16'd1);
    chk("ok_enable_held", 16'(enable_out), 16'd0);
    @(negedge clk);
    clr_fault = 1'b1;
    @(negedge clk);
    clr_fault = 1'b0;
    chk("clr_fault", 16'(fault_latched), 16'd0);
    chk("clr_enable", 16'(enable_out), 16'd1);
    chk("clr_led_n", 16'(led_n), 16'h001D);

    // LOW / UNDER candidates alternate: persistence keeps restarting.
    repeat (10) begin
      block(16'h0850);
      block(16'h0880);
    end
    idle(6);
    chk("alternate_zone", 16'(zone), 16'd3);

    for (int i = 0; i < 8; i++) send(16'(i));
    aq.push_back(16'd3);
    idle(6);
    chk("trunc_avg", avg_volt, 16'd3);

    // Reset in the middle of a block; the partial block and settle progress are lost.
    repeat (5) send(16'h0100);
    do_reset("midrst");
    settle4();
    push_zone(3'd3, 5'b11101, 1'b1);
    block(16'h0900);
    idle(6);
    chk("post_rst_avg", avg_volt, 16'h0900);

    // Classification boundary and HYST edge on the LOW zone.
    do_reset("bndrst");
    settle4();
    push_zone(3'd1, 5'b10111, 1'b0);
    block(16'h0860);
    idle(6);
    repeat (16) block(16'h0870);
    idle(6);
    chk("low_hyst_edge_zone", 16'(zone), 16'd1);
    repeat (15) block(16'h0871);
    push_zone(3'd2, 5'b11011, 1'b0);
    block(16'h0871);
    idle(6);

    // Constant raw code run (settle strobes included).
    do_reset("stkrst");
    push_zone(3'd3, 5'b11101, 1'b1);
    for (int i = 0; i < 7; i++) aq.push_back(16'h0A00);
    repeat (64) send(16'h0A00);
    @(negedge clk);
    volt_vld = 1'b0;
    chk("stuck_after_64", 16'(adc_stuck), EXP_STUCK);
    chk("stuck_fault_lag", 16'(fault_latched), 16'd0);
    @(negedge clk);
    chk("stuck_fault", 16'(fault_latched), EXP_STUCK);
    send(16'h0A01);
    @(negedge clk);
    volt_vld = 1'b0;
    chk("stuck_cleared", 16'(adc_stuck), 16'd0);
    idle(10);

    for (int i = 0; i < 100 && (aq.size() != 0 || zq.size() != 0); i++) @(negedge clk);
    chk("scoreboard_drained", 16'(aq.size() + zq.size()), 16'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
